// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer: RGMII receive framer, strips preamble/SFD and packs bytes into a DATA_BYTES-wide stream.
// Ports: gmii_rx_clk/rst (sync, active-high), rx_ctl_rise (DV), rx_ctl_fall (DV^ER), gmii_rxd;
//        m_data/m_keep/m_valid/m_sop/m_eop/m_err stream, frame_len/frame_len_vld of last frame,
//        frame_cnt/err_cnt/pre_err_cnt statistics.
// Optional: RGMII_INBAND_STATUS_EN adds link_up/link_speed/full_duplex/status_chg decoded from idle rxd.
module gmii_rx_framer #(
  parameter int DATA_BYTES    = 4,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int PRE_MIN       = 1,
  parameter int CNT_W         = 32
) (
  input  logic                      gmii_rx_clk,
  input  logic                      rst,
  input  logic                      rx_ctl_rise,
  input  logic                      rx_ctl_fall,
  input  logic [7:0]                gmii_rxd,
  output logic [8*DATA_BYTES-1:0]   m_data,
  output logic [DATA_BYTES-1:0]     m_keep,
  output logic                      m_valid,
  output logic                      m_sop,
  output logic                      m_eop,
  output logic                      m_err,
  output logic [15:0]               frame_len,
  output logic                      frame_len_vld,
  output logic [CNT_W-1:0]          frame_cnt,
  output logic [CNT_W-1:0]          err_cnt,
`ifdef RGMII_INBAND_STATUS_EN
  output logic [CNT_W-1:0]          pre_err_cnt,
  output logic                      link_up,
  output logic [1:0]                link_speed,
  output logic                      full_duplex,
  output logic                      status_chg
`else
  output logic [CNT_W-1:0]          pre_err_cnt
`endif
);
  localparam int IW = $clog2(DATA_BYTES + 1);
  localparam logic [1:0] IDLE = 2'd0, PRE = 2'd1, DATA = 2'd2, DROP = 2'd3;
  localparam logic [IW-1:0] FULL = IW'(DATA_BYTES);
  localparam logic [15:0] MIN_L = 16'(MIN_FRAME_LEN), MAX_L = 16'(MAX_FRAME_LEN);
  localparam logic [3:0] PRE_L = 4'(PRE_MIN);
  logic dv_q, er_q, armed, sticky, first;
  logic [7:0] rxd_q;
  logic [1:0] st;
  logic [3:0] pre_cnt, pre_base;
  logic [8*DATA_BYTES-1:0] word;
  logic [IW-1:0] idx;
  logic [15:0] len;
  logic [DATA_BYTES-1:0] keep;
  logic pre_go, is55, sfd_ok, eop_now, word_out, eop_err;
  // the IDLE->PRE byte is itself a preamble candidate, so IDLE evaluates it like PRE
  always_comb begin
    keep = '0;
    for (int i = 0; i < DATA_BYTES; i++) keep[i] = IW'(i) < idx;
    pre_go   = dv_q && ((st == IDLE && armed) || st == PRE);
    pre_base = (st == PRE) ? pre_cnt : 4'd0;
    is55     = !er_q && rxd_q == 8'h55;
    sfd_ok   = !er_q && rxd_q == 8'hD5 && pre_base >= PRE_L;
    eop_now  = st == DATA && (!dv_q || len == MAX_L);
    word_out = st == DATA && dv_q && len != MAX_L && idx == FULL;
    eop_err  = sticky || len < MIN_L || dv_q;
  end
  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      {dv_q, er_q, rxd_q, armed, sticky, first} <= '0;
      {st, pre_cnt, word, idx, len} <= '0;
      {m_data, m_keep, m_valid, m_sop, m_eop, m_err, frame_len, frame_len_vld} <= '0;
      {frame_cnt, err_cnt, pre_err_cnt} <= '0;
    end else begin
      dv_q  <= rx_ctl_rise;
      er_q  <= rx_ctl_rise ^ rx_ctl_fall;
      rxd_q <= gmii_rxd;
      // after reset, a burst already in flight is ignored until DV drops
      armed <= armed | !rx_ctl_rise;
      m_valid       <= eop_now | word_out;
      m_sop         <= first & (eop_now | word_out);
      m_eop         <= eop_now;
      m_err         <= eop_now & eop_err;
      frame_len_vld <= eop_now;
      if (eop_now | word_out) begin
        m_data <= word;
        m_keep <= keep;
        first  <= 1'b0;
      end
      if (eop_now) begin
        frame_len <= len;
        frame_cnt <= frame_cnt + CNT_W'(1);
        if (eop_err) err_cnt <= err_cnt + CNT_W'(1);
      end
      case (st)
        IDLE, PRE: begin
          if (pre_go) begin
            if (is55) begin
              st      <= PRE;
              pre_cnt <= (pre_base == 4'hF) ? pre_base : pre_base + 4'd1;
            end else if (sfd_ok) begin
              st     <= DATA;
              word   <= '0;
              idx    <= '0;
              len    <= '0;
              sticky <= 1'b0;
              first  <= 1'b1;
            end else begin
              st          <= DROP;
              pre_err_cnt <= pre_err_cnt + CNT_W'(1);
            end
          end else if (st == PRE) st <= IDLE;
        end
        DATA: begin
          // a full word waits for the next byte or DV low so its eop flag is exact
          if (eop_now) st <= dv_q ? DROP : IDLE;
          else if (dv_q) begin
            sticky <= sticky | er_q;
            len    <= len + 16'd1;
            if (idx == FULL) begin
              word <= (8*DATA_BYTES)'(rxd_q);
              idx  <= IW'(1);
            end else begin
              word[8*idx +: 8] <= rxd_q;
              idx <= idx + IW'(1);
            end
          end
        end
        default: if (!dv_q) st <= IDLE;
      endcase
    end
  end
`ifdef RGMII_INBAND_STATUS_EN
  logic [3:0] prev_s, stat;
  logic prev_v, qual, take;
  always_comb begin
    qual = !dv_q && !er_q;
    take = qual && prev_v && prev_s == rxd_q[3:0] && stat != rxd_q[3:0];
  end
  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      {prev_s, stat, prev_v, status_chg} <= '0;
    end else begin
      prev_s     <= rxd_q[3:0];
      prev_v     <= qual;
      status_chg <= take;
      if (take) stat <= rxd_q[3:0];
    end
  end
  assign link_up     = stat[0];
  assign link_speed  = stat[2:1];
  assign full_duplex = stat[3];
`endif
endmodule

// File: tb/tb_gmii_rx_framer.sv
// tb_gmii_rx_framer: directed self-checking bench for gmii_rx_framer with DATA_BYTES=4.
module tb_gmii_rx_framer;
  logic clk = 0, rst = 1, rx_ctl_rise = 0, rx_ctl_fall = 0;
  logic [7:0] gmii_rxd = 0;
  logic [31:0] m_data;
  logic [3:0] m_keep;
  logic m_valid, m_sop, m_eop, m_err, frame_len_vld;
  logic [15:0] frame_len;
  logic [31:0] frame_cnt, err_cnt, pre_err_cnt;
`ifdef RGMII_INBAND_STATUS_EN
  logic link_up, full_duplex, status_chg;
  logic [1:0] link_speed;
  int chg_n = 0;
  always @(negedge clk) if (status_chg) chg_n++;
`endif
  int errors = 0, checks = 0;
  typedef struct {
    logic [31:0] d;
    logic [3:0] k;
    logic s, e, r;
    logic [15:0] fl;
    logic flv;
  } w_t;
  w_t q[$];
  w_t z, f0, lw;
  always #4 clk = ~clk;
  gmii_rx_framer #(.DATA_BYTES(4)) dut (
    .gmii_rx_clk(clk), .rst(rst), .rx_ctl_rise(rx_ctl_rise), .rx_ctl_fall(rx_ctl_fall),
    .gmii_rxd(gmii_rxd), .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_sop(m_sop),
    .m_eop(m_eop), .m_err(m_err), .frame_len(frame_len), .frame_len_vld(frame_len_vld),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt),
`ifdef RGMII_INBAND_STATUS_EN
    .pre_err_cnt(pre_err_cnt), .link_up(link_up), .link_speed(link_speed),
    .full_duplex(full_duplex), .status_chg(status_chg)
`else
    .pre_err_cnt(pre_err_cnt)
`endif
  );
  always @(negedge clk) if (m_valid) q.push_back('{m_data, m_keep, m_sop, m_eop, m_err, frame_len, frame_len_vld});
  task tick(input logic dv, input logic er, input logic [7:0] d);
    rx_ctl_rise = dv;
    rx_ctl_fall = dv ^ er;
    gmii_rxd = d;
    @(posedge clk);
    #1;
  endtask
  task idle(input int n);
    repeat (n) tick(0, 0, 8'h00);
  endtask
  task frame(input int len, input int er_at);
    repeat (7) tick(1, 0, 8'h55);
    tick(1, 0, 8'hD5);
    for (int i = 0; i < len; i++) tick(1, i == er_at, 8'(i));
  endtask
  task grab();
    f0 = q.size() > 0 ? q[0] : z;
    lw = q.size() > 0 ? q[q.size()-1] : z;
  endtask
  task test_reset();
    rst = 1;
    idle(3);
    rst = 0;
    idle(2);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", m_valid); end
    checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h want=0", m_data); end
    checks++; if ({frame_cnt, err_cnt, pre_err_cnt} !== 96'h0) begin errors++; $display("FAIL reset_cnts got=%0d/%0d/%0d want=0", frame_cnt, err_cnt, pre_err_cnt); end
    checks++; if (frame_len !== 16'h0) begin errors++; $display("FAIL reset_len got=%0d want=0", frame_len); end
  endtask
  task test_min_frame();
    q.delete(); frame(64, -1); idle(4); grab();
    checks++; if (q.size() != 16) begin errors++; $display("FAIL min_words got=%0d want=16", q.size()); end
    checks++; if ({f0.s, f0.e, f0.d} !== {2'b10, 32'h03020100}) begin errors++; $display("FAIL min_first got=%b%b %h want=10 03020100", f0.s, f0.e, f0.d); end
    checks++; if ({lw.s, lw.e, lw.k, lw.r, lw.d} !== {2'b01, 4'hF, 1'b0, 32'h3F3E3D3C}) begin errors++; $display("FAIL min_last got=%b%b %h %b %h want=01 f 0 3f3e3d3c", lw.s, lw.e, lw.k, lw.r, lw.d); end
    checks++; if ({lw.fl, lw.flv} !== {16'd64, 1'b1}) begin errors++; $display("FAIL min_len got=%0d/%b want=64/1", lw.fl, lw.flv); end
    checks++; if (frame_cnt !== 1) begin errors++; $display("FAIL min_fcnt got=%0d want=1", frame_cnt); end
  endtask
  task test_partial();
    q.delete(); frame(65, -1); idle(4); grab();
    checks++; if (q.size() != 17) begin errors++; $display("FAIL part_words got=%0d want=17", q.size()); end
    checks++; if ({lw.e, lw.k, lw.r, lw.d} !== {1'b1, 4'h1, 1'b0, 32'h00000040}) begin errors++; $display("FAIL part_last got=%b %h %b %h want=1 1 0 00000040", lw.e, lw.k, lw.r, lw.d); end
    checks++; if (frame_cnt !== 2) begin errors++; $display("FAIL part_fcnt got=%0d want=2", frame_cnt); end
  endtask
  task test_length();
    int eops;
    q.delete(); frame(60, -1); idle(4); grab();
    checks++; if ({lw.e, lw.r, lw.fl} !== {2'b11, 16'd60}) begin errors++; $display("FAIL short_eop got=%b%b %0d want=11 60", lw.e, lw.r, lw.fl); end
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL short_ecnt got=%0d want=1", err_cnt); end
    q.delete(); frame(1600, -1);
    checks++; if (q.size() != 380) begin errors++; $display("FAIL trunc_early got=%0d want=380", q.size()); end
    idle(4); grab();
    eops = 0;
    foreach (q[i]) eops += int'(q[i].e);
    checks++; if (q.size() != 380 || eops != 1) begin errors++; $display("FAIL trunc_words got=%0d/%0d want=380/1", q.size(), eops); end
    checks++; if ({lw.e, lw.r, lw.k, lw.fl} !== {2'b11, 4'h3, 16'd1518}) begin errors++; $display("FAIL trunc_eop got=%b%b %h %0d want=11 3 1518", lw.e, lw.r, lw.k, lw.fl); end
    checks++; if (err_cnt !== 2) begin errors++; $display("FAIL trunc_ecnt got=%0d want=2", err_cnt); end
    q.delete(); frame(1518, -1); idle(4); grab();
    checks++; if ({q.size() == 380, lw.e, lw.r, lw.fl} !== {3'b110, 16'd1518}) begin errors++; $display("FAIL max_legal got=%0d %b%b %0d want=380 10 1518", q.size(), lw.e, lw.r, lw.fl); end
    q.delete(); frame(3, -1); idle(4); grab();
    checks++; if ({q.size() == 1, lw.s, lw.e, lw.k, lw.r, lw.d} !== {3'b111, 4'h7, 1'b1, 32'h00020100}) begin errors++; $display("FAIL one_word got=%0d %b%b %h %b %h want=1 11 7 1 00020100", q.size(), lw.s, lw.e, lw.k, lw.r, lw.d); end
    checks++; if ({frame_cnt, err_cnt} !== {32'd6, 32'd3}) begin errors++; $display("FAIL len_cnts got=%0d/%0d want=6/3", frame_cnt, err_cnt); end
  endtask
  task test_bad_preamble();
    q.delete();
    tick(1, 0, 8'h55); tick(1, 0, 8'h55); tick(1, 0, 8'h5D);
    for (int i = 0; i < 20; i++) tick(1, 0, 8'hD5);
    idle(4);
    checks++; if (q.size() != 0) begin errors++; $display("FAIL pre_words got=%0d want=0", q.size()); end
    checks++; if (pre_err_cnt !== 1) begin errors++; $display("FAIL pre_ecnt got=%0d want=1", pre_err_cnt); end
    frame(64, -1); idle(4); grab();
    checks++; if ({q.size() == 16, f0.s, lw.e, lw.r, frame_cnt} !== {4'b1110, 32'd7}) begin errors++; $display("FAIL pre_next got=%0d %b%b%b %0d want=16 110 7", q.size(), f0.s, lw.e, lw.r, frame_cnt); end
  endtask
  task test_rx_err();
    int errs;
    q.delete(); frame(100, 30); idle(4); grab();
    errs = 0;
    foreach (q[i]) errs += int'(q[i].r);
    checks++; if ({q.size() == 25, errs == 1, lw.e, lw.r} !== 4'b1111) begin errors++; $display("FAIL rxer got=%0d/%0d %b%b want=25/1 11", q.size(), errs, lw.e, lw.r); end
    checks++; if (err_cnt !== 4) begin errors++; $display("FAIL rxer_ecnt got=%0d want=4", err_cnt); end
    q.delete();
    repeat (3) tick(0, 1, 8'h0E);
    frame(64, -1); idle(4); grab();
    checks++; if ({q.size() == 16, lw.r, err_cnt} !== {2'b10, 32'd4}) begin errors++; $display("FAIL false_carrier got=%0d %b %0d want=16 0 4", q.size(), lw.r, err_cnt); end
  endtask
  task test_reset_mid();
    repeat (7) tick(1, 0, 8'h55);
    tick(1, 0, 8'hD5);
    for (int i = 0; i < 40; i++) tick(1, 0, 8'(i));
    rst = 1; tick(1, 0, 8'd40); rst = 0;
    q.delete();
    for (int i = 41; i < 100; i++) tick(1, 0, 8'(i));
    idle(4);
    checks++; if ({q.size() == 0, frame_cnt, pre_err_cnt} !== {1'b1, 64'h0}) begin errors++; $display("FAIL rstmid_quiet got=%0d %0d %0d want=0 0 0", q.size(), frame_cnt, pre_err_cnt); end
    frame(64, -1); idle(4); grab();
    checks++; if ({q.size() == 16, f0.s, lw.e, frame_cnt} !== {3'b111, 32'd1}) begin errors++; $display("FAIL rstmid_next got=%0d %b%b %0d want=16 11 1", q.size(), f0.s, lw.e, frame_cnt); end
  endtask
  task test_back_to_back();
    q.delete(); frame(64, -1); tick(0, 0, 8'h00); frame(65, -1); idle(4); grab();
    checks++; if (q.size() != 33) begin errors++; $display("FAIL b2b_words got=%0d want=33", q.size()); end
    else begin
      checks++; if ({q[15].e, q[15].d, q[16].s, q[16].d, lw.k} !== {1'b1, 32'h3F3E3D3C, 1'b1, 32'h03020100, 4'h1}) begin errors++; $display("FAIL b2b_join got=%b %h %b %h %h want=1 3f3e3d3c 1 03020100 1", q[15].e, q[15].d, q[16].s, q[16].d, lw.k); end
    end
    checks++; if (frame_cnt !== 3) begin errors++; $display("FAIL b2b_fcnt got=%0d want=3", frame_cnt); end
  endtask
`ifdef RGMII_INBAND_STATUS_EN
  task test_inband();
    chg_n = 0;
    repeat (4) tick(0, 0, 8'h0D);
    checks++; if ({link_up, link_speed, full_duplex, chg_n == 1} !== 5'b11011) begin errors++; $display("FAIL inband_set got=%b %b %b %0d want=1 10 1 1", link_up, link_speed, full_duplex, chg_n); end
    tick(0, 0, 8'h00);
    repeat (4) tick(0, 0, 8'h0D);
    checks++; if ({link_up, link_speed, full_duplex, chg_n == 1} !== 5'b11011) begin errors++; $display("FAIL inband_glitch got=%b %b %b %0d want=1 10 1 1", link_up, link_speed, full_duplex, chg_n); end
  endtask
`endif
  initial begin
    z = '{32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0};
    test_reset();
    test_min_frame();
    test_partial();
    test_length();
    test_bad_preamble();
    test_rx_err();
    test_reset_mid();
    test_back_to_back();
`ifdef RGMII_INBAND_STATUS_EN
    test_inband();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
